// File: rtl/mc_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, opcodes, ALU/immediate codes, mux selects.
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SRL   = 4'd3;
  localparam logic [3:0] ALU_SRA   = 4'd4;
  localparam logic [3:0] ALU_AND   = 4'd5;
  localparam logic [3:0] ALU_OR    = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_SLTU  = 4'd10;

  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_U = 3'd1;
  localparam logic [2:0] EXT_S = 3'd2;
  localparam logic [2:0] EXT_B = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10;
  localparam logic [1:0] A_REG = 2'b00, A_PC = 2'b01, A_OLDPC = 2'b10;
  localparam logic [1:0] B_REG = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  localparam logic [1:0] ERR_NONE = 2'b00, ERR_ILL = 2'b01, ERR_TMO = 2'b10;

  typedef struct packed {
    logic lui, auipc, alu_r, alu_i, load, store, branch, jal, jalr;
  } iclass_t;

  // Branches reuse the ALU as a comparator; the flag result feeds br_cond.
  function automatic logic [3:0] alu_dec(input iclass_t c, input logic [2:0] f3, input logic f7b5);
    alu_dec = ALU_ADD;
    if (c.lui) alu_dec = ALU_PASSB;
    else if (c.branch) begin
      case (f3)
        3'b100:  alu_dec = ALU_SLT;
        3'b110:  alu_dec = ALU_SLTU;
        default: alu_dec = ALU_SUB;
      endcase
    end else if (c.alu_r) begin
      case (f3)
        3'b000:  alu_dec = f7b5 ? ALU_SUB : ALU_ADD;
        3'b100:  alu_dec = ALU_XOR;
        3'b110:  alu_dec = ALU_OR;
        3'b111:  alu_dec = ALU_AND;
        default: alu_dec = ALU_ADD;
      endcase
    end else if (c.alu_i) begin
      case (f3)
        3'b001:  alu_dec = ALU_SLL;
        3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
        default: alu_dec = ALU_ADD;
      endcase
    end
  endfunction

  function automatic logic [2:0] ext_dec(input iclass_t c);
    if (c.lui || c.auipc) ext_dec = EXT_U;
    else if (c.store)     ext_dec = EXT_S;
    else if (c.branch)    ext_dec = EXT_B;
    else if (c.jal)       ext_dec = EXT_J;
    else                  ext_dec = EXT_I;
  endfunction
endpackage

// File: rtl/mc_seq_ctrl_if.sv
// Unified-memory request/ready handshake between the sequencer and the memory port.
interface mc_seq_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, mem_we, iord, input mem_ready);
  modport slave  (input mem_req, mem_we, iord, output mem_ready);
endinterface

// File: rtl/mc_seq_ctrl_instr_class.sv
// Combinational instruction classifier: opcode/funct fields to one-hot class plus illegal flag.
module mc_instr_class
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output iclass_t    cls,
  output logic       illegal
);
  always_comb begin
    cls = '0;
    case (op)
      OPC_LUI:    cls.lui   = 1'b1;
      OPC_AUIPC:  cls.auipc = 1'b1;
      // funct7b5 only selects SUB on 000; set elsewhere it is a reserved encoding
      OPC_OP:     cls.alu_r = (funct3 == 3'b000) ||
                              (!funct7b5 && (funct3 == 3'b100 || funct3 == 3'b110 || funct3 == 3'b111));
      OPC_IMM:    cls.alu_i = (funct3 == 3'b000) || (funct3 == 3'b101) ||
                              (funct3 == 3'b001 && !funct7b5);
      OPC_LOAD:   cls.load  = 1'b1;
      OPC_STORE:  cls.store = 1'b1;
      OPC_BRANCH: cls.branch = (funct3 == 3'b000) || (funct3 == 3'b100) || (funct3 == 3'b110);
      OPC_JAL:    cls.jal   = 1'b1;
      OPC_JALR:   cls.jalr  = 1'b1;
      default:    cls = '0;
    endcase
    illegal = ~|cls;
  end
endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with run/step control, instret and memory timeout trap.
module mc_seq_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic             step,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             br_cond,
  mc_seq_ctrl_if.master    mem,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [3:0]       alu_op,
  output logic [2:0]       ext_op,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       err
);
  localparam int TW = $clog2(TMO_CYCLES + 1);

  state_t      state, nxt;
  logic        one_shot;
  logic [TW-1:0] wcnt;
  iclass_t     cls;
  logic        illegal;
  logic        req, we, iord, retire, set_ill, set_tmo, tmo_hit, cnt_clr;

  mc_instr_class u_cls (.op(op), .funct3(funct3), .funct7b5(funct7b5), .cls(cls), .illegal(illegal));

  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign mem.iord    = iord;
  assign tmo_hit     = (wcnt == TW'(TMO_CYCLES - 1));
  assign cnt_clr     = (state != nxt) && (nxt == S_FETCH || nxt == S_MEM);
  assign halted      = (state == S_IDLE) || (state == S_ERR);

  always_comb begin
    nxt = state;
    req = 1'b0; we = 1'b0; iord = 1'b0;
    ir_we = 1'b0; mdr_we = 1'b0; pc_we = 1'b0; pc_src = 1'b0; reg_we = 1'b0;
    wb_sel = WB_ALU; alu_a_sel = A_REG; alu_b_sel = B_REG; alu_op = ALU_ADD; ext_op = EXT_I;
    retire = 1'b0; set_ill = 1'b0; set_tmo = 1'b0;
    unique case (state)
      S_IDLE: if (run || step) nxt = S_FETCH;
      S_FETCH: begin
        req = 1'b1; alu_a_sel = A_PC; alu_b_sel = B_FOUR;
        if (mem.mem_ready) begin
          ir_we = 1'b1; pc_we = 1'b1; nxt = S_DECODE;
        end else if (tmo_hit) begin
          nxt = S_ERR; set_tmo = 1'b1;
        end
      end
      S_DECODE: begin
        // oldPC+imm lands in ALUOut: branch/jal target for EXEC
        ext_op = ext_dec(cls); alu_a_sel = A_OLDPC; alu_b_sel = B_IMM;
        if (illegal) begin
          nxt = S_ERR; set_ill = 1'b1;
        end else nxt = S_EXEC;
      end
      S_EXEC: begin
        ext_op = ext_dec(cls); alu_op = alu_dec(cls, funct3, funct7b5);
        if (cls.load || cls.store) begin
          alu_b_sel = B_IMM; nxt = S_MEM;
        end else if (cls.branch) begin
          pc_we = br_cond; retire = 1'b1;
        end else if (cls.jal) begin
          alu_a_sel = A_OLDPC; alu_b_sel = B_IMM;
          reg_we = 1'b1; wb_sel = WB_PC; pc_we = 1'b1; retire = 1'b1;
        end else if (cls.jalr) begin
          alu_b_sel = B_IMM; pc_src = 1'b1;
          reg_we = 1'b1; wb_sel = WB_PC; pc_we = 1'b1; retire = 1'b1;
        end else begin
          alu_a_sel = cls.auipc ? A_OLDPC : A_REG;
          alu_b_sel = cls.alu_r ? B_REG : B_IMM;
          nxt = S_WB;
        end
      end
      S_MEM: begin
        req = 1'b1; iord = 1'b1; we = cls.store;
        if (mem.mem_ready) begin
          if (cls.store) retire = 1'b1;
          else begin
            mdr_we = 1'b1; nxt = S_WB;
          end
        end else if (tmo_hit) begin
          nxt = S_ERR; set_tmo = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1; wb_sel = cls.load ? WB_MDR : WB_ALU; retire = 1'b1;
      end
      S_ERR: nxt = S_ERR;
      default: nxt = S_IDLE;
    endcase
    if (retire) nxt = (run && !one_shot) ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      one_shot <= 1'b0;
      wcnt     <= '0;
      instret  <= '0;
      err      <= ERR_NONE;
    end else begin
      state <= nxt;
      if (state == S_IDLE && nxt == S_FETCH) one_shot <= step && !run;
      if (cnt_clr) wcnt <= '0;
      else if (req && !mem.mem_ready) wcnt <= wcnt + TW'(1);
      if (retire)  instret <= instret + CNT_W'(1);
      if (set_ill) err <= ERR_ILL;
      if (set_tmo) err <= ERR_TMO;
    end
  end
endmodule
